rsh_share_ctrl: RTL and testbench
=================================

// Module: rsh_share_ctrl
// PURPOSE
//  - Shares one 7-bit combinational right shifter between two requesters.
//  - Requesters use valid/ready; the shifter sits outside this block on sh_a/sh_f/sh_y.
//  - Arbitration is round-robin by default; one response is buffered with the requester id.
//  - Sits between the datapath issue logic and the shared shifter instance.
// PARAMETERS
//  DATA_W  7  operand/result width; must equal shifter width
//  AMT_W   3  shift-amount width; must equal shifter select width
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous reset, active low
//  req_valid    in   2       per-requester request valid ([0]=req0, [1]=req1)
//  req_ready    out  2       per-requester accept; at most one bit high
//  req0_a       in   DATA_W  req0 operand
//  req0_f       in   AMT_W   req0 shift amount
//  req1_a       in   DATA_W  req1 operand
//  req1_f       in   AMT_W   req1 shift amount
//  sh_a         out  DATA_W  operand to shared shifter (registered)
//  sh_f         out  AMT_W   amount to shared shifter (registered)
//  sh_y         in   DATA_W  shifter result (combinational from sh_a/sh_f)
//  rsp_valid    out  1       response valid
//  rsp_ready    in   1       response consumer ready
//  rsp_y        out  DATA_W  shifted result
//  rsp_id       out  1       requester that owns rsp_y
//  busy         out  1       high in SHIFT or RESP
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE, ptr=0.
//    - sh_a=0, sh_f=0, rsp_y=0, rsp_id=0, rsp_valid=0, busy=0.
//    - req_ready forced 2'b00 while rst_n=0.
//  - Reset mid-operation drops the in-flight transaction; no response is issued.
//  - FSM IDLE -> SHIFT -> RESP -> IDLE. No other transitions.
//  - IDLE:
//    - grant = arbiter(req_valid, ptr); req_ready = grant (combinational).
//    - On any grant: latch the granted a/f into sh_a/sh_f, latch rsp_id, go SHIFT.
//  - SHIFT (1 cycle): rsp_y <= sh_y, rsp_valid <= 1, go RESP.
//  - RESP:
//    - Hold rsp_y/rsp_id stable while rsp_valid && !rsp_ready.
//    - On rsp_ready: rsp_valid <= 0, ptr <= ~rsp_id, go IDLE.
//  - Timing:
//    - Accept edge at cycle T; rsp_valid first high in T+2.
//    - Next accept no earlier than T+3, so peak throughput is 1 op per 3 cycles.
//  - Arbiter: only one valid -> grant it. Both valid -> grant req[ptr].
//  - Requesters hold a/f stable while valid and not ready; the block does not check this.
//  - req_ready=0 in SHIFT and RESP, and when no request is valid.
//  - sh_a/sh_f hold their last value outside IDLE grants.
//  - No width change: rsp_y is sh_y unmodified.
// CONFIGURATION
//  RSH_CTRL_FIXPRIO_EN
//    - defined: fixed priority; req0 always wins when both are valid; ptr is unused and constant 0.
//    - undefined (default): round-robin as above.
// TESTING
//  1. Reset, then req0 a=7'h5A f=3 -> accepted at T, rsp_valid at T+2, rsp_y=7'h0B, rsp_id=0.
//  2. req1 a=7'h7F f=0 -> rsp_y=7'h7F. Then f=7 -> rsp_y=7'h00. Then a=7'h40 f=6 -> 7'h01. All rsp_id=1.
//  3. Both valid continuously after reset:
//     - grants alternate 0,1,0,1 with rsp_ready=1; one response per 3 cycles.
//     - with RSH_CTRL_FIXPRIO_EN, all grants go to 0.
//  4. rsp_ready=0 for 5 cycles in RESP:
//     - rsp_valid stays 1; rsp_y/rsp_id stable; req_ready=0; busy=1.
//     - release -> IDLE next cycle.
//  5. rst_n low during SHIFT:
//     - all outputs 0 immediately (async); no response after release.
//     - first grant after release goes to req0 when both are valid.

Source files
------------

// File: rtl/rsh_share_ctrl.sv
// Arbitrates two requesters onto one external 7-bit right shifter and buffers one tagged response.
// Define RSH_CTRL_FIXPRIO_EN for fixed priority (req0 wins); the default build is round-robin.
`timescale 1ns/1ps
module rsh_share_ctrl #(
  parameter int DATA_W = 7,
  parameter int AMT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [AMT_W-1:0]  req0_f,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [AMT_W-1:0]  req1_f,
  output logic [DATA_W-1:0] sh_a,
  output logic [AMT_W-1:0]  sh_f,
  input  logic [DATA_W-1:0] sh_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  logic       ptr;
  logic [1:0] grant;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // requesters keep a/f stable until then, and rsp_y/rsp_id hold until rsp_ready.
  always_comb begin
    grant = 2'b00;
    if (rst_n && state == IDLE) begin
      if (req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                    grant = req_valid;
    end
  end

  assign req_ready = grant;

`ifdef RSH_CTRL_FIXPRIO_EN
  assign ptr = 1'b0;
`else
  // Priority passes to the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (state == RESP && rsp_ready) begin
      ptr <= ~rsp_id;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_f      <= '0;
      rsp_y     <= '0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            sh_a   <= grant[1] ? req1_a : req0_a;
            sh_f   <= grant[1] ? req1_f : req0_f;
            rsp_id <= grant[1];
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_y     <= sh_y;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsh_share_ctrl.sv
// Bench for rsh_share_ctrl: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of the arbiter and response buffer.
`timescale 1ns/1ps
module tb_rsh_share_ctrl;
  localparam int DATA_W = 7;
  localparam int AMT_W  = 3;
  localparam int W      = 1 + DATA_W + AMT_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_a, req1_a, sh_a, sh_y, rsp_y;
  logic [AMT_W-1:0]  req0_f, req1_f, sh_f;
  logic              rsp_valid, rsp_ready, rsp_id, busy;

  rsh_share_ctrl #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_f(req0_f), .req1_a(req1_a), .req1_f(req1_f),
    .sh_a(sh_a), .sh_f(sh_f), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .busy(busy)
  );

  // External shared shifter
  assign sh_y = sh_a >> sh_f;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one entry {id, a, f, y} per accepted request, age = edges since acceptance
  logic [W-1:0]      exp_q[$];
  logic              m_busy = 1'b0;
  int                m_age = 0;
  logic              m_ptr = 1'b0;
  logic [1:0]        model_acc = 2'b00;
  logic [1:0]        m_g;
  logic [DATA_W-1:0] m_a;
  logic [AMT_W-1:0]  m_f;
  logic [DATA_W-1:0] m_y;
  logic [W-1:0]      m_e;
  logic [W-1:0]      c_e;

  function automatic logic [1:0] arb(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_age = 0; m_ptr = 1'b0; model_acc = 2'b00;
        exp_q.delete();
      end else begin
        model_acc = 2'b00;
        if (!m_busy) begin
          m_g = arb(req_valid, m_ptr);
          if (m_g != 2'b00) begin
            m_a = m_g[1] ? req1_a : req0_a;
            m_f = m_g[1] ? req1_f : req0_f;
            m_y = m_a >> m_f;
            exp_q.push_back({m_g[1], m_a, m_f, m_y});
            model_acc = m_g;
            m_busy = 1'b1;
            m_age = 1;
          end
        end else if (m_age >= 2) begin
          if (rsp_ready) begin
            m_e = exp_q.pop_front();
`ifdef RSH_CTRL_FIXPRIO_EN
            m_ptr = 1'b0;
`else
            m_ptr = ~m_e[W-1];
`endif
            m_busy = 1'b0;
            m_age = 0;
          end
        end else begin
          m_age++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
      end else if (!m_busy) begin
        check("idle_req_ready", req_ready, arb(req_valid, m_ptr));
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
      end else begin
        c_e = exp_q[0];
        check("op_req_ready", req_ready, 0);
        check("op_busy", busy, 1);
        check("op_sh_a", sh_a, c_e[W-2 -: DATA_W]);
        check("op_sh_f", sh_f, c_e[DATA_W +: AMT_W]);
        check("op_rsp_valid", rsp_valid, (m_age >= 2) ? 1 : 0);
        if (m_age >= 2) begin
          check("rsp_y", rsp_y, c_e[DATA_W-1:0]);
          check("rsp_id", rsp_id, c_e[W-1]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input logic id);
    bit got;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready[id]) begin
        got = 1;
        step();
        break;
      end
      step();
    end
    check("accept_seen", got, 1);
  endtask

  task automatic run_single(input logic id, input logic [DATA_W-1:0] a,
                            input logic [AMT_W-1:0] f, input logic [DATA_W-1:0] y);
    if (id) begin req1_a = a; req1_f = f; end
    else    begin req0_a = a; req0_f = f; end
    req_valid = id ? 2'b10 : 2'b01;
    rsp_ready = 1'b1;
    wait_accept(id);
    req_valid = 2'b00;
    check("t1_rsp_valid_low", rsp_valid, 0);
    step();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_y", rsp_y, y);
    check("t2_rsp_id", rsp_id, id);
    step();
    check("back_idle_busy", busy, 0);
  endtask

  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (4) step();
  endtask

  int ids[4];
  int n_rsp, cyc, last, exp_id;

  initial begin
    req_valid = 2'b00; rsp_ready = 1'b1;
    req0_a = '0; req0_f = '0; req1_a = '0; req1_f = '0;
    repeat (3) step();
    check("reset_sh_a", sh_a, 0);
    check("reset_sh_f", sh_f, 0);
    check("reset_rsp_y", rsp_y, 0);
    check("reset_rsp_id", rsp_id, 0);
    rst_n = 1'b1;
    step();

    run_single(1'b0, 7'h5A, 3'd3, 7'h0B);
    run_single(1'b1, 7'h7F, 3'd0, 7'h7F);
    run_single(1'b1, 7'h7F, 3'd7, 7'h00);
    run_single(1'b1, 7'h40, 3'd6, 7'h01);

    // Both requesters valid continuously from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_a = 7'h6C; req0_f = 3'd2; req1_a = 7'h35; req1_f = 3'd1;
    req_valid = 2'b11;
    n_rsp = 0; cyc = 0; last = 0;
    for (int c = 0; c < 40 && n_rsp < 4; c++) begin
      step();
      cyc++;
      if (rsp_valid) begin
        ids[n_rsp] = rsp_id;
        if (n_rsp > 0) check("rr_gap", cyc - last, 3);
        last = cyc;
        n_rsp++;
      end
    end
    check("rr_count", n_rsp, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef RSH_CTRL_FIXPRIO_EN
      exp_id = 0;
`else
      exp_id = i % 2;
`endif
      check("rr_grant_id", ids[i], exp_id);
    end
    drain();

    // Consumer stalls for five cycles
    req0_a = 7'h33; req0_f = 3'd1;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    wait_accept(1'b0);
    req1_a = 7'h11; req1_f = 3'd2;
    req_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_y", rsp_y, 7'h19);
      check("hold_rsp_id", rsp_id, 0);
      check("hold_req_ready", req_ready, 0);
      check("hold_busy", busy, 1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("release_busy", busy, 0);
    check("release_grant", req_ready, 2'b10);
    drain();

    // Reset while the shifter stage is active
    req0_a = 7'h7E; req0_f = 3'd4;
    req_valid = 2'b01;
    wait_accept(1'b0);
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_ready", req_ready, 0);
    check("async_rsp_valid", rsp_valid, 0);
    check("async_busy", busy, 0);
    check("async_sh_a", sh_a, 0);
    check("async_sh_f", sh_f, 0);
    check("async_rsp_y", rsp_y, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", req_ready, 2'b01);
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || model_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          if (i == 0) begin
            req0_a = DATA_W'($urandom_range(0, 127));
            req0_f = AMT_W'($urandom_range(0, 7));
          end else begin
            req1_a = DATA_W'($urandom_range(0, 127));
            req1_f = AMT_W'($urandom_range(0, 7));
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
